// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the millisecond countdown alarm: register map,
// CTRL bit positions and controller state encoding.
package timer_alarm_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RELOAD = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_PERIOD_BIT = 1;
    localparam int CTRL_IRQEN_BIT  = 2;

    localparam int STATUS_PEND_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_alarm_tick_detect.sv
// Turns any change of the free-running millisecond count into a one-cycle tick.
// Jumps of several counts and the FFFF->0000 wrap each give exactly one tick.
module timer_alarm_tick_detect #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_prev_q;

    // Resetting to 0 means a count sitting at 0 after reset release gives no tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_prev_q <= '0;
        end else begin
            cnt_prev_q <= cnt_i;
        end
    end

    assign tick_o = (cnt_i != cnt_prev_q);

endmodule

// File: rtl/timer_alarm.sv
// CPU-programmable countdown alarm clocked by millisecond count advances,
// with one-shot/periodic modes, a pending flag and a registered level IRQ.
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             irq_ack,
    output logic             irq,
    output logic [1:0]       dbg_state_o
);

    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic             periodic_q, periodic_d;
    logic             irq_en_q, irq_en_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             irq_q, irq_d;

    logic             tick;
    logic             ctrl_wr;
    logic             reload_wr;
    logic             status_clr;
    logic             expire;
    logic [WIDTH-1:0] ctrl_view;
    logic [WIDTH-1:0] status_view;

    timer_alarm_tick_detect #(
        .WIDTH(WIDTH)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .cnt_i (cnt_in),
        .tick_o(tick)
    );

    assign ctrl_wr    = wr_en && (wr_addr == ADDR_CTRL);
    assign reload_wr  = wr_en && (wr_addr == ADDR_RELOAD);
    assign status_clr = wr_en && (wr_addr == ADDR_STATUS) && wr_data[STATUS_PEND_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            reload_q   <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            rd_data_q  <= rd_data_d;
            irq_q      <= irq_d;
        end
    end

    // A CTRL write takes priority over a same-cycle tick, which is dropped.
    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        count_d    = count_q;
        expire     = 1'b0;

        if (ctrl_wr) begin
            periodic_d = wr_data[CTRL_PERIOD_BIT];
            irq_en_d   = wr_data[CTRL_IRQEN_BIT];
            if (wr_data[CTRL_EN_BIT]) begin
                if (reload_q != '0) begin
                    enable_d = 1'b1;
                    count_d  = reload_q;
                    state_d  = ST_RUN;
                end
            end else begin
                enable_d = 1'b0;
                state_d  = ST_IDLE;
            end
        end else if ((state_q == ST_RUN) && tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expire = 1'b1;
                // A periodic timer whose RELOAD was zeroed mid-run stops like a one-shot.
                if (periodic_q && (reload_q != '0)) begin
                    count_d = reload_q;
                end else begin
                    count_d  = '0;
                    enable_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
        end
    end

    always_comb begin
        reload_d = reload_q;
        if (reload_wr) begin
            reload_d = wr_data;
        end
    end

    // Expiry beats a clear arriving in the same cycle.
    always_comb begin
        pending_d = pending_q;
        if (expire) begin
            pending_d = 1'b1;
        end else if (irq_ack || status_clr) begin
            pending_d = 1'b0;
        end
    end

    assign irq_d = pending_q & irq_en_q;

    always_comb begin
        ctrl_view                  = '0;
        ctrl_view[CTRL_EN_BIT]     = enable_q;
        ctrl_view[CTRL_PERIOD_BIT] = periodic_q;
        ctrl_view[CTRL_IRQEN_BIT]  = irq_en_q;
        status_view                  = '0;
        status_view[STATUS_PEND_BIT] = pending_q;
    end

    // Reads sample the current registers, so a same-cycle write is not yet visible.
    always_comb begin
        rd_data_d = '0;
        case (rd_addr)
            ADDR_CTRL:   rd_data_d = ctrl_view;
            ADDR_RELOAD: rd_data_d = reload_q;
            ADDR_COUNT:  rd_data_d = count_q;
            ADDR_STATUS: rd_data_d = status_view;
            default:     rd_data_d = '0;
        endcase
    end

    assign rd_data     = rd_data_q;
    assign irq         = irq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: register access, one-shot, periodic,
// clear/expiry collision, wrap, disable, CTRL/tick collision and reset.
module tb_timer_alarm;
    import timer_alarm_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] cnt_in;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        irq_ack;
    logic        irq;
    logic [1:0]  dbg_state;

    int n_pass;
    int n_total;

    timer_alarm #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .irq_ack    (irq_ack),
        .irq        (irq),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        rd_addr = a;
        cyc();
        v = rd_data;
    endtask

    task automatic tick_once();
        cnt_in = cnt_in + 16'd1;
        cyc();
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        logic [15:0] v;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        n_total++;
        if (rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h want 0000", rd_data); else n_pass++;
        n_total++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_total++;
            if (v !== 16'h0) $display("FAIL reset_reg%0d: got %h want 0000", a, v); else n_pass++;
        end
    endtask

    task automatic test_one_shot();
        logic [15:0] v;
        wr(ADDR_RELOAD, 16'd3);
        wr(ADDR_CTRL, 16'h0005);
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd3) $display("FAIL oneshot_count_start: got %0d want 3", v); else n_pass++;
        for (int k = 1; k <= 2; k++) begin
            tick_once();
            rd(ADDR_COUNT, v);
            n_total++;
            if (v !== 16'(3 - k)) $display("FAIL oneshot_count_t%0d: got %0d want %0d", k, v, 3 - k); else n_pass++;
        end
        tick_once();
        n_total++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_early: got %b want 0", irq); else n_pass++;
        rd(ADDR_STATUS, v);
        n_total++;
        if (v !== 16'h0001) $display("FAIL oneshot_pending: got %h want 0001", v); else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq: got %b want 1", irq); else n_pass++;
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd0) $display("FAIL oneshot_count_end: got %0d want 0", v); else n_pass++;
        rd(ADDR_CTRL, v);
        n_total++;
        if (v !== 16'h0004) $display("FAIL oneshot_ctrl: got %h want 0004", v); else n_pass++;
        n_total++;
        if (dbg_state !== ST_DONE) $display("FAIL oneshot_state: got %0d want %0d", dbg_state, ST_DONE); else n_pass++;
        ack();
        cyc();
        n_total++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_ack: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_periodic();
        logic [15:0] v;
        int n_irq;
        n_irq = 0;
        wr(ADDR_RELOAD, 16'd2);
        wr(ADDR_CTRL, 16'h0007);
        for (int k = 1; k <= 6; k++) begin
            tick_once();
            rd(ADDR_COUNT, v);
            n_total++;
            if (v !== ((k % 2 == 1) ? 16'd1 : 16'd2))
                $display("FAIL periodic_count_t%0d: got %0d want %0d", k, v, (k % 2 == 1) ? 1 : 2);
            else n_pass++;
            n_total++;
            if (irq !== (k % 2 == 0))
                $display("FAIL periodic_irq_t%0d: got %b want %b", k, irq, (k % 2 == 0));
            else n_pass++;
            if (irq === 1'b1) begin
                n_irq++;
                ack();
            end
        end
        n_total++;
        if (n_irq != 3) $display("FAIL periodic_irq_count: got %0d want 3", n_irq); else n_pass++;
        wr(ADDR_CTRL, 16'h0000);
    endtask

    task automatic test_collision();
        logic [15:0] v;
        wr(ADDR_RELOAD, 16'd2);
        wr(ADDR_CTRL, 16'h0007);
        tick_once();
        cnt_in  = cnt_in + 16'd1;
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        rd(ADDR_STATUS, v);
        n_total++;
        if (v !== 16'h0001) $display("FAIL collide_pending: got %h want 0001", v); else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL collide_irq: got %b want 1", irq); else n_pass++;
        cyc();
        n_total++;
        if (irq !== 1'b1) $display("FAIL collide_irq_hold: got %b want 1", irq); else n_pass++;
        wr(ADDR_STATUS, 16'h0001);
        rd(ADDR_STATUS, v);
        n_total++;
        if (v !== 16'h0000) $display("FAIL collide_status_clr: got %h want 0000", v); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL collide_irq_clr: got %b want 0", irq); else n_pass++;
        wr(ADDR_CTRL, 16'h0000);
    endtask

    task automatic test_wrap_reload_zero();
        logic [15:0] v;
        cnt_in = 16'hFFFF;
        cyc();
        cyc();
        wr(ADDR_RELOAD, 16'd1);
        wr(ADDR_CTRL, 16'h0005);
        tick_once();
        rd(ADDR_STATUS, v);
        n_total++;
        if (v !== 16'h0001) $display("FAIL wrap_pending: got %h want 0001", v); else n_pass++;
        n_total++;
        if (dbg_state !== ST_DONE) $display("FAIL wrap_state: got %0d want %0d", dbg_state, ST_DONE); else n_pass++;
        wr(ADDR_STATUS, 16'h0001);
        wr(ADDR_CTRL, 16'h0000);
        wr(ADDR_RELOAD, 16'd0);
        wr(ADDR_CTRL, 16'h0001);
        rd(ADDR_CTRL, v);
        n_total++;
        if (v !== 16'h0000) $display("FAIL reload0_ctrl: got %h want 0000", v); else n_pass++;
        n_total++;
        if (dbg_state !== ST_IDLE) $display("FAIL reload0_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        rd(ADDR_STATUS, v);
        n_total++;
        if (v !== 16'h0000) $display("FAIL reload0_pending: got %h want 0000", v); else n_pass++;
    endtask

    task automatic test_disable_reload();
        logic [15:0] v;
        wr(ADDR_RELOAD, 16'd5);
        wr(ADDR_CTRL, 16'h0001);
        tick_once();
        tick_once();
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd3) $display("FAIL dis_count_run: got %0d want 3", v); else n_pass++;
        wr(ADDR_RELOAD, 16'd10);
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd3) $display("FAIL dis_reload_no_effect: got %0d want 3", v); else n_pass++;
        wr(ADDR_CTRL, 16'h0000);
        tick_once();
        tick_once();
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd3) $display("FAIL dis_count_frozen: got %0d want 3", v); else n_pass++;
        n_total++;
        if (dbg_state !== ST_IDLE) $display("FAIL dis_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        wr(ADDR_CTRL, 16'h0001);
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd10) $display("FAIL dis_reenable_count: got %0d want 10", v); else n_pass++;
        n_total++;
        if (dbg_state !== ST_RUN) $display("FAIL dis_reenable_state: got %0d want %0d", dbg_state, ST_RUN); else n_pass++;
        wr(ADDR_CTRL, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        wr(ADDR_RELOAD, 16'd4);
        wr(ADDR_CTRL, 16'h0001);
        tick_once();
        wr_en   = 1'b1;
        wr_addr = ADDR_CTRL;
        wr_data = 16'h0001;
        cnt_in  = cnt_in + 16'd1;
        cyc();
        wr_en   = 1'b0;
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd4) $display("FAIL b2b_ctrl_beats_tick: got %0d want 4", v); else n_pass++;
        rd_addr = ADDR_RELOAD;
        wr(ADDR_RELOAD, 16'd9);
        n_total++;
        if (rd_data !== 16'd4) $display("FAIL b2b_read_prewrite: got %0d want 4", rd_data); else n_pass++;
        cyc();
        n_total++;
        if (rd_data !== 16'd9) $display("FAIL b2b_read_postwrite: got %0d want 9", rd_data); else n_pass++;
        wr(ADDR_CTRL, 16'h0000);
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        wr(ADDR_RELOAD, 16'd1);
        wr(ADDR_CTRL, 16'h0007);
        tick_once();
        wr(ADDR_RELOAD, 16'd6);
        wr(ADDR_CTRL, 16'h0007);
        tick_once();
        tick_once();
        rd(ADDR_COUNT, v);
        n_total++;
        if (v !== 16'd4) $display("FAIL rstmid_count_pre: got %0d want 4", v); else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL rstmid_irq_pre: got %b want 1", irq); else n_pass++;
        #2;
        rst    = 1'b1;
        cnt_in = 16'h0000;
        #1;
        n_total++;
        if (rd_data !== 16'h0) $display("FAIL rstmid_rd_data: got %h want 0000", rd_data); else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b want 0", irq); else n_pass++;
        n_total++;
        if (dbg_state !== ST_IDLE) $display("FAIL rstmid_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
        cyc();
        rst = 1'b0;
        #1;
        n_total++;
        if (dut.u_tick.tick_o !== 1'b0) $display("FAIL rstmid_no_tick: got %b want 0", dut.u_tick.tick_o); else n_pass++;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_total++;
            if (v !== 16'h0) $display("FAIL rstmid_reg%0d: got %h want 0000", a, v); else n_pass++;
        end
    endtask

    // sequence and final report
    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        cnt_in  = 16'h0000;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 16'h0000;
        rd_addr = 2'd0;
        irq_ack = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        test_reset();
        test_one_shot();
        test_periodic();
        test_collision();
        test_wrap_reload_zero();
        test_disable_reload();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
